op_slot_sequencer: RTL
======================

Name: op_slot_sequencer

Overview:
- Upstream timing stage of the operator pipeline.
- On each sample_clk_en pulse it walks all 36 operator slots (bank 0 ops 0..17, then bank 1 ops 0..17).
- For each slot it emits a one-cycle op_valid strobe with registered bank_num, op_num and ch_num.
- These are the inputs the delay shift-registers carry down the operator/channel pipeline. It also flags the end of each frame and sample-rate overruns.

Parameters:
- CYCLES_PER_SLOT, 4: clocks between consecutive op_valid strobes; legal range >=1.
- NUM_BANKS, 2: banks per frame.
- OPS_PER_BANK, 18: operator slots per bank.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- sample_clk_en  input  1  one-cycle pulse; requests a new frame.
- overrun_clr  input  1  clears the sticky overrun flag.
- op_valid  output  1  one-cycle strobe; slot outputs are valid this cycle.
- bank_num  output  1  current bank (0..NUM_BANKS-1).
- op_num  output  5  current operator within bank (0..OPS_PER_BANK-1).
- ch_num  output  4  channel owning op_num (0..8).
- frame_done  output  1  one-cycle pulse, coincident with the last slot's op_valid.
- busy  output  1  high while a frame is in progress.
- overrun  output  1  sticky: a sample_clk_en arrived while busy and was not accepted.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; div counter and slot counters 0.
- States: IDLE, RUN.
- IDLE -> RUN on a clock edge with sample_clk_en=1.
  - The next cycle has op_valid=1, bank_num=0, op_num=0, ch_num=0, busy=1.
  - Request-to-first-strobe latency is 1 clock.
- In RUN, div counts 0..CYCLES_PER_SLOT-1 and wraps.
  - op_valid=1 exactly when div==0.
  - The slot advances on the edge where div wraps: op_num 0..17, then wraps to 0 and bank_num increments.
  - With CYCLES_PER_SLOT=1, op_valid is continuously high for 36 cycles.
- Slot outputs hold their value between strobes; they are registered, not combinational.
- ch_num = (op_num/6)*3 + (op_num mod 3), giving:
  - ops 0,3 -> ch 0; ops 1,4 -> ch 1; ops 2,5 -> ch 2
  - ops 6,9 -> ch 3; ops 7,10 -> ch 4; ops 8,11 -> ch 5
  - ops 12,15 -> ch 6; ops 13,16 -> ch 7; ops 14,17 -> ch 8
  - Produced in the same cycle as op_num.
- Last slot (bank 1, op 17): frame_done=1 with its op_valid.
  - When its div period ends, RUN -> IDLE.
  - busy falls, and bank/op/ch return to 0.
  - Frame length is 36*CYCLES_PER_SLOT clocks.
- sample_clk_en during RUN:
  - It is ignored, except on the final clock of the frame (last slot, div==CYCLES_PER_SLOT-1).
  - On that final clock it is accepted as a back-to-back start: slot 0 op_valid next cycle, busy stays 1, no overrun.
  - Any other ignored pulse sets overrun.
- Overrun flag:
  - overrun_clr=1 clears overrun on the next edge.
  - A simultaneous set and clear leaves overrun=1 (set wins).
- Reset mid-frame: outputs return to 0 immediately (async); the sequencer restarts only on the next sample_clk_en after release.
- sample_clk_en held high for multiple cycles: only the first edge starts a frame; following cycles count as overrun.

Decomposition:
- The opl3 shared package holds:
  - constants NUM_BANKS, OPS_PER_BANK, NUM_CHANNELS_PER_BANK=9;
  - typedefs for bank_num_t, op_num_t, ch_num_t;
  - a function op_to_ch(op_num_t) implementing the channel mapping.
- No sub-module; a single module with an FSM plus counters.

Test Plan:
1. CYCLES_PER_SLOT=4, one sample_clk_en at cycle 10:
   - op_valid at cycles 11,15,...,151 (36 strobes);
   - slot sequence bank0 op0..17 then bank1 op0..17;
   - frame_done only at cycle 151; busy falls at 155.
2. ch_num check, every strobe of scenario 1:
   - op 4 -> ch 1, op 9 -> ch 3, op 14 -> ch 8, op 17 -> ch 8 in both banks.
3. Overrun: second sample_clk_en at cycle 50 of scenario 1:
   - overrun=1 from cycle 51; frame is undisturbed;
   - overrun_clr at cycle 200 -> overrun=0 at 201.
4. Back-to-back, CYCLES_PER_SLOT=1:
   - sample_clk_en at cycles 0 and 36 -> op_valid continuous for cycles 1..72;
   - frame_done at cycles 36 and 72; overrun stays 0.
5. Reset asserted at cycle 30 mid-frame:
   - all outputs 0 asynchronously;
   - no op_valid after release until sample_clk_en, which restarts at bank 0 op 0.
6. Simultaneous overrun set and overrun_clr in the same cycle -> overrun remains 1.

Source files
------------

// File: rtl/op_slot_sequencer_pkg.sv
// Shared operator-slot constants, slot/channel types and the operator-to-channel mapping.
package op_slot_sequencer_pkg;

    localparam int unsigned NUM_BANKS             = 2;
    localparam int unsigned OPS_PER_BANK          = 18;
    localparam int unsigned NUM_CHANNELS_PER_BANK = 9;

    typedef logic [0:0] bank_num_t;
    typedef logic [4:0] op_num_t;
    typedef logic [3:0] ch_num_t;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } seq_state_e;

    // Operators come in groups of six (two per channel, three channels per group).
    function automatic ch_num_t op_to_ch(op_num_t op);
        op_num_t grp;
        op_num_t sub;
        grp = op / 5'd6;
        sub = op % 5'd3;
        return ch_num_t'(grp * 5'd3 + sub);
    endfunction

endpackage

// File: rtl/op_slot_sequencer.sv
// Walks every operator slot once per sample_clk_en, strobing registered bank/op/channel
// numbers for the downstream operator pipeline and flagging frame end and overruns.
module op_slot_sequencer #(
    parameter int unsigned CYCLES_PER_SLOT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_clk_en,
    input  logic       overrun_clr,
    output logic       op_valid,
    output logic [0:0] bank_num,
    output logic [4:0] op_num,
    output logic [3:0] ch_num,
    output logic       frame_done,
    output logic       busy,
    output logic       overrun
);
    import op_slot_sequencer_pkg::*;

    localparam int unsigned DivW = (CYCLES_PER_SLOT > 1) ? $clog2(CYCLES_PER_SLOT) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CYCLES_PER_SLOT - 1);
    localparam bank_num_t BankLast = bank_num_t'(NUM_BANKS - 1);
    localparam op_num_t OpLast = op_num_t'(OPS_PER_BANK - 1);

    seq_state_e      state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    bank_num_t       bank_q, bank_d;
    op_num_t         op_q, op_d;
    ch_num_t         ch_q, ch_d;
    logic            op_valid_q, op_valid_d;
    logic            frame_done_q, frame_done_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;

    logic div_wrap;
    logic last_slot;
    logic final_clk;
    logic start;
    logic ignored;

    always_comb begin
        div_wrap  = (div_q == DivLast);
        last_slot = (bank_q == BankLast) && (op_q == OpLast);
        final_clk = (state_q == StRun) && div_wrap && last_slot;
        // A request landing on the very last clock of a frame chains straight into the next one.
        start     = sample_clk_en && ((state_q == StIdle) || final_clk);
        ignored   = sample_clk_en && (state_q == StRun) && !final_clk;
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bank_d  = bank_q;
        op_d    = op_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    div_d   = '0;
                    bank_d  = '0;
                    op_d    = '0;
                end
            end
            StRun: begin
                if (div_wrap) begin
                    div_d = '0;
                    if (last_slot) begin
                        state_d = start ? StRun : StIdle;
                        bank_d  = '0;
                        op_d    = '0;
                    end else if (op_q == OpLast) begin
                        op_d   = '0;
                        bank_d = bank_q + 1'b1;
                    end else begin
                        op_d = op_q + 5'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                div_d   = '0;
                bank_d  = '0;
                op_d    = '0;
            end
        endcase

        op_valid_d   = (state_d == StRun) && (div_d == '0);
        frame_done_d = op_valid_d && (bank_d == BankLast) && (op_d == OpLast);
        busy_d       = (state_d == StRun);
        ch_d         = op_to_ch(op_d);

        // Set has priority over clear so a coincident overrun is never lost.
        if (ignored) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            div_q        <= '0;
            bank_q       <= '0;
            op_q         <= '0;
            ch_q         <= '0;
            op_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bank_q       <= bank_d;
            op_q         <= op_d;
            ch_q         <= ch_d;
            op_valid_q   <= op_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign op_valid   = op_valid_q;
    assign bank_num   = bank_q;
    assign op_num     = op_q;
    assign ch_num     = ch_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule
